fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the team's `fifo` (DWIDTH-wide data_in, wr_en, full) among NREQ requesters. A requester wins a grant, then streams up to MAX_BURST words into the FIFO under full back-pressure. The grant is then released and the next requester in rotation is served. The block sits between producer blocks and the `fifo` write side; the FIFO read side is untouched.

Parameters:
NREQ, 4, number of requesters (2..8)
DWIDTH, 5, word width; must match the `fifo` DWIDTH
MAX_BURST, 4, maximum words written per grant (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset)
req  input  NREQ  per-requester write request; bit i is requester i
req_data  input  NREQ*DWIDTH  per-requester write word; requester i occupies bits [i*DWIDTH +: DWIDTH]
gnt  output  NREQ  registered one-hot grant; all-zero when idle
ack  output  NREQ  word accepted this cycle; only the granted bit can be 1
fifo_full  input  1  `fifo` full flag
fifo_wr_en  output  1  drives `fifo` wr_en
fifo_data_in  output  DWIDTH  drives `fifo` data_in
busy  output  1  1 while in GRANT

Behaviour:
- Reset (rst=0, asynchronous):
  - State is IDLE, gnt=0, burst_cnt=0, rr_ptr=NREQ-1, so requester 0 has first priority.
  - fifo_wr_en, ack, fifo_data_in and busy all read 0 immediately, without waiting for a clock edge.
- State IDLE:
  - busy=0, fifo_wr_en=0, ack=0, fifo_data_in=0.
  - If req is nonzero at a rising edge: gnt is set to the one-hot of the first requesting index searching rr_ptr+1, rr_ptr+2, … modulo NREQ; burst_cnt is cleared to 0; state moves to GRANT.
  - Arbitration latency is 1 cycle from req to gnt. No word is written in the IDLE cycle.
- State GRANT (owner = index of the set gnt bit):
  - Combinational outputs:
    - fifo_wr_en = req[owner] & ~fifo_full.
    - ack[owner] = fifo_wr_en.
    - fifo_data_in = owner's slice of req_data.
  - At each edge where fifo_wr_en=1, burst_cnt increments.
  - Release at an edge when either condition holds:
    - req[owner]=0, or
    - fifo_wr_en=1 and burst_cnt==MAX_BURST-1.
  - On release: gnt<=0, rr_ptr<=owner, state moves to IDLE. One idle bubble cycle always separates grants, including re-grant of the same sole requester.
  - fifo_full=1: grant is held, no write occurs, burst_cnt is held. There is no timeout.
- Requester protocol:
  - Hold req high and req_data stable until ack.
  - A word is consumed exactly on the cycle its ack=1.
  - The next word is presented in the following cycle.
  - Deasserting req ends the burst at the next edge.
- Non-owner req bits are ignored during GRANT and never produce ack.
- burst_cnt width is $clog2(MAX_BURST)+1; the counter never wraps.
- With MAX_BURST=1, every accepted word causes a release.
- Invariant: gnt is always zero or one-hot. At most one FIFO write per cycle.
- Reset mid-burst: the in-flight grant is abandoned. Words already acked stay in the FIFO. The partial burst is not resumed after reset.

Test Plan:
- Reset: hold rst=0 with req=4'b1111 -> gnt=0, fifo_wr_en=0, busy=0. Release rst -> gnt=4'b0001 one cycle later.
- Sole long burst: req=4'b0100 with 6 words 31..26, MAX_BURST=4, fifo never full.
  - Expect FIFO writes 31,30,29,28; gnt drops for one cycle; re-grant to 4'b0100; writes 27,26.
  - Reading the `fifo` returns 31..26 in order.
- Rotation: all four req held high, each writing one word per ack.
  - Grant order is 0,1,2,3,0.
  - Each grant lasts 4 write cycles plus 1 idle cycle.
- Full back-pressure: fill the `fifo` (AWIDTH=8, 256 words) then hold req[1].
  - While full=1: fifo_wr_en=0, ack=0, gnt stays 4'b0010.
  - One FIFO read -> exactly one write (ack[1] pulses once).
- Early release: req[2] drops after 2 acked words -> gnt=0 at the next edge, rr_ptr=2. If req[3] is pending it is granted next.
- Async reset mid-burst: drive rst=0 between clock edges during the 2nd word -> fifo_wr_en and gnt are 0 before the next edge. The FIFO contains only the words acked before reset.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NREQ producers.
// A winner streams up to MAX_BURST words under full back-pressure, then yields.

module fifo_wr_arbiter_lane #(
  parameter int DWIDTH = 5
) (
  input  logic              gnt,
  input  logic              req,
  input  logic              fifo_full,
  input  logic [DWIDTH-1:0] data,
  output logic              ack,
  output logic [DWIDTH-1:0] data_masked
);
  assign ack         = gnt & req & ~fifo_full;
  assign data_masked = gnt ? data : '0;
endmodule

module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DWIDTH    = 5,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        ack,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [DWIDTH-1:0]      fifo_data_in,
  output logic                   busy
);
  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                        state, state_nxt;
  logic [NREQ-1:0]               gnt_nxt, pick_oh;
  logic [PW-1:0]                 rr_ptr, rr_nxt, owner, pick;
  logic [BW-1:0]                 burst_cnt, burst_nxt;
  logic [NREQ-1:0][DWIDTH-1:0]   lane_in, lane_out;
  logic                          req_own, last_word, rel;

  assign lane_in = req_data;

  // gnt is zero outside GRANT, so every lane output is already gated by state
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    fifo_wr_arbiter_lane #(.DWIDTH(DWIDTH)) u_lane (
      .gnt        (gnt[i]),
      .req        (req[i]),
      .fifo_full  (fifo_full),
      .data       (lane_in[i]),
      .ack        (ack[i]),
      .data_masked(lane_out[i])
    );
  end

  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < NREQ; i++) fifo_data_in |= lane_out[i];
  end

  assign fifo_wr_en = |ack;
  assign busy       = (state == GRANT);
  assign req_own    = |(req & gnt);
  assign last_word  = fifo_wr_en && (burst_cnt == BW'(MAX_BURST - 1));
  assign rel        = ~req_own | last_word;

  always_comb begin
    owner = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) owner = PW'(i);
  end

  // first requester after rr_ptr, wrapping modulo NREQ
  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign pick_oh = NREQ'(1) << pick;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    rr_nxt    = rr_ptr;
    burst_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          gnt_nxt   = pick_oh;
          burst_nxt = '0;
        end
      end
      GRANT: begin
        if (fifo_wr_en) burst_nxt = burst_cnt + BW'(1);
        if (rel) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          rr_nxt    = owner;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      gnt       <= '0;
      burst_cnt <= '0;
      rr_ptr    <= PW'(NREQ - 1);
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      burst_cnt <= burst_nxt;
      rr_ptr    <= rr_nxt;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter; the bench plays the producers and
// logs every fifo write so order and content can be checked.

module tb_fifo_wr_arbiter;
  localparam int NREQ = 4, DWIDTH = 5, MAX_BURST = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ*DWIDTH-1:0] req_data;
  logic [NREQ-1:0]        gnt, ack;
  logic                   fifo_full;
  logic                   fifo_wr_en;
  logic [DWIDTH-1:0]      fifo_data_in;
  logic                   busy;

  int checks = 0, errors = 0;
  int base [NREQ];
  int cnt  [NREQ];
  int rem  [NREQ];
  logic [DWIDTH-1:0] wlog[$];
  logic [NREQ-1:0]   gtrace[$];

  fifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .ack(ack),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (rem[i] > 0);
      req_data[i*DWIDTH +: DWIDTH] = DWIDTH'(base[i] - cnt[i]);
    end
  endtask

  task automatic setup(input int i, input int b, input int n);
    base[i] = b; cnt[i] = 0; rem[i] = n;
  endtask

  // one clock: sample, log the write, advance producers, check invariants
  task automatic cyc();
    logic [NREQ-1:0]   a;
    logic              w;
    logic [DWIDTH-1:0] d;
    #1;
    a = ack; w = fifo_wr_en; d = fifo_data_in;
    @(posedge clk);
    if (w) wlog.push_back(d);
    for (int i = 0; i < NREQ; i++)
      if (a[i]) begin cnt[i]++; rem[i]--; end
    #1;
    drive();
    gtrace.push_back(gnt);
    #1;
    chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
    chk("ack_in_gnt", 32'((ack & ~gnt) == '0), 1);
  endtask

  initial begin
    int n;
    rst = 1'b0; fifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) setup(i, 8*i + 7, 8);
    drive();
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_wr_en", 32'(fifo_wr_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_data", 32'(fifo_data_in), 0);
    cyc(); cyc();
    chk("rst_held_gnt", 32'(gnt), 0);

    // rotation: every lane has 8 words, so two full bursts each
    rst = 1'b1;
    gtrace.delete(); wlog.delete();
    for (int k = 0; k < 24; k++) cyc();
    chk("rot_g0", 32'(gtrace[0]), 1);
    chk("rot_g3", 32'(gtrace[3]), 1);
    chk("rot_bubble0", 32'(gtrace[4]), 0);
    chk("rot_g1", 32'(gtrace[5]), 2);
    chk("rot_bubble1", 32'(gtrace[9]), 0);
    chk("rot_g2", 32'(gtrace[10]), 4);
    chk("rot_g3b", 32'(gtrace[15]), 8);
    chk("rot_g0b", 32'(gtrace[20]), 1);
    chk("rot_w0", 32'(wlog[0]), 7);
    chk("rot_w4", 32'(wlog[4]), 15);
    chk("rot_w15", 32'(wlog[15]), 28);
    n = 0;
    while ((req != '0 || busy) && n < 60) begin cyc(); n++; end
    chk("rot_drained", 32'(n < 60), 1);
    chk("rot_count", 32'(wlog.size()), 32);
    chk("rot_last", 32'(wlog[31]), 24);
    chk("rot_w16", 32'(wlog[16]), 3);

    // sole long burst of 6 words from lane 2
    gtrace.delete(); wlog.delete();
    setup(2, 31, 6); drive();
    cyc();
    chk("sole_gnt", 32'(gnt), 4);
    chk("sole_ack", 32'(ack), 4);
    chk("sole_data", 32'(fifo_data_in), 31);
    chk("sole_busy", 32'(busy), 1);
    for (int k = 0; k < 8; k++) cyc();
    chk("sole_bubble", 32'(gtrace[4]), 0);
    chk("sole_regrant", 32'(gtrace[5]), 4);
    chk("sole_end", 32'(gtrace[8]), 0);
    chk("sole_count", 32'(wlog.size()), 6);
    for (int k = 0; k < 6; k++) chk("sole_word", 32'(wlog[k]), 32'(31 - k));

    // full back-pressure on lane 1
    wlog.delete();
    fifo_full = 1'b1;
    setup(1, 9, 3); drive();
    cyc();
    chk("full_gnt", 32'(gnt), 2);
    chk("full_wr_en", 32'(fifo_wr_en), 0);
    chk("full_ack", 32'(ack), 0);
    cyc(); cyc(); cyc();
    chk("full_hold_gnt", 32'(gnt), 2);
    chk("full_no_write", 32'(wlog.size()), 0);
    fifo_full = 1'b0;
    #1;
    chk("full_one_ack", 32'(ack), 2);
    cyc();
    fifo_full = 1'b1;
    cyc();
    chk("full_one_write", 32'(wlog.size()), 1);
    chk("full_word", 32'(wlog[0]), 9);
    chk("full_still_gnt", 32'(gnt), 2);
    fifo_full = 1'b0;
    cyc(); cyc(); cyc();
    chk("full_words", 32'(wlog.size()), 3);
    chk("full_last", 32'(wlog[2]), 7);
    chk("full_release", 32'(gnt), 0);

    // early release of lane 2 with lane 3 pending
    gtrace.delete(); wlog.delete();
    setup(2, 5, 2); setup(3, 17, 1); drive();
    for (int k = 0; k < 7; k++) cyc();
    chk("early_g2", 32'(gtrace[0]), 4);
    chk("early_rel", 32'(gtrace[3]), 0);
    chk("early_g3", 32'(gtrace[4]), 8);
    chk("early_end", 32'(gtrace[6]), 0);
    chk("early_count", 32'(wlog.size()), 3);
    chk("early_w1", 32'(wlog[1]), 4);
    chk("early_w2", 32'(wlog[2]), 17);

    // async reset during the second word of a lane-0 burst
    wlog.delete();
    setup(0, 12, 4); drive();
    cyc(); cyc();
    chk("ar_ack", 32'(ack), 1);
    chk("ar_data", 32'(fifo_data_in), 11);
    #2 rst = 1'b0;
    #1;
    chk("ar_wr_en", 32'(fifo_wr_en), 0);
    chk("ar_gnt", 32'(gnt), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_data0", 32'(fifo_data_in), 0);
    cyc();
    rem[0] = 0; drive();
    rst = 1'b1;
    cyc(); cyc();
    chk("ar_log", 32'(wlog.size()), 1);
    chk("ar_word", 32'(wlog[0]), 12);
    chk("ar_idle", 32'(gnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
